// File: rtl/kws_seq_pkg.sv
// Shared types, bus idle values and layer-selection helper
// for the keyword-spotting layer sequencer.
package kws_seq_pkg;

    localparam int MAX_LAYERS = 16;
    localparam int MAX_LW     = 4;

    localparam logic       PSRAM_IDLE_SCK    = 1'b0;
    localparam logic       PSRAM_IDLE_CE_N   = 1'b1;
    localparam logic [3:0] PSRAM_IDLE_DOUT   = 4'b0;
    localparam logic [3:0] PSRAM_IDLE_DOUTEN = 4'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_GUARD,
        ST_FINISH
    } seq_state_t;

    typedef struct packed {
        logic              valid;
        logic [MAX_LW-1:0] idx;
    } layer_sel_t;

    // Lowest set bit of mask strictly above idx.
    function automatic layer_sel_t lowest_set_above(
        input logic [MAX_LAYERS-1:0] mask,
        input logic [MAX_LW-1:0]     idx
    );
        layer_sel_t sel;
        sel = '0;
        for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                sel.valid = 1'b1;
                sel.idx   = MAX_LW'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/kws_layer_sequencer_if.sv
// Engine launch/completion handshake and PSRAM bus bundle.
// master = sequencer side, slave = engines and pad side.
interface kws_layer_sequencer_if #(
    parameter int NUM_LAYERS = 8
);

    logic [NUM_LAYERS-1:0]   layer_start;
    logic [NUM_LAYERS-1:0]   layer_done;
    logic [NUM_LAYERS-1:0]   eng_sck;
    logic [NUM_LAYERS-1:0]   eng_ce_n;
    logic [4*NUM_LAYERS-1:0] eng_dout;
    logic [4*NUM_LAYERS-1:0] eng_douten;
    logic                    psram_sck;
    logic                    psram_ce_n;
    logic [3:0]              psram_dout;
    logic [3:0]              psram_douten;

    modport master (
        output layer_start,
        output psram_sck,
        output psram_ce_n,
        output psram_dout,
        output psram_douten,
        input  layer_done,
        input  eng_sck,
        input  eng_ce_n,
        input  eng_dout,
        input  eng_douten
    );

    modport slave (
        input  layer_start,
        input  psram_sck,
        input  psram_ce_n,
        input  psram_dout,
        input  psram_douten,
        output layer_done,
        output eng_sck,
        output eng_ce_n,
        output eng_dout,
        output eng_douten
    );

endinterface

// File: rtl/kws_next_layer_pe.sv
// Priority encoder: next enabled layer above the current one.
module kws_next_layer_pe
    import kws_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int LW         = $clog2(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] mask,
    input  logic [LW-1:0]         cur_layer,
    output logic                  next_valid,
    output logic [LW-1:0]         next_idx
);

    layer_sel_t sel;

    // Search the widened mask and narrow back to the layer index.
    always_comb begin
        sel        = lowest_set_above(MAX_LAYERS'(mask), MAX_LW'(cur_layer));
        next_valid = sel.valid;
        next_idx   = sel.idx[LW-1:0];
    end

endmodule

// File: rtl/kws_layer_sequencer.sv
// Layer sequencer and single-port PSRAM arbiter for the KWS engines.
// Optional KWS_SEQ_PERF_EN adds per-layer RUN-cycle counters.
module kws_layer_sequencer
    import kws_seq_pkg::*;
#(
    parameter int NUM_LAYERS   = 8,
    parameter int LW           = $clog2(NUM_LAYERS),
    parameter int TIMEOUT_W    = 20,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_mask,
    input  logic [TIMEOUT_W-1:0]  timeout_limit,
    kws_layer_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LW-1:0]         err_layer,
    output logic [LW-1:0]         cur_layer
`ifdef KWS_SEQ_PERF_EN
    ,
    output logic [NUM_LAYERS*TIMEOUT_W-1:0] perf_cycles
`endif
);

    localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1);
    localparam logic [3:0] GUARD_LAST =
        (GUARD_CYCLES > 0) ? 4'(GUARD_CYCLES - 1) : 4'd0;

    seq_state_t            state;
    seq_state_t            adv_state;
    logic [NUM_LAYERS-1:0] mask_q;
    logic [TIMEOUT_W-1:0]  wd;
    logic [TIMEOUT_W-1:0]  wd_inc;
    logic [3:0]            gcnt;
    layer_sel_t            first_sel;
    logic                  first_valid;
    logic [LW-1:0]         first_idx;
    logic                  next_valid;
    logic [LW-1:0]         next_idx;
    logic [NUM_LAYERS-1:0] adv_pulse;
    logic                  grant;
    logic                  start_acc;
    logic                  abort_acc;
    logic                  run_done;
    logic                  timeout_hit;

    kws_next_layer_pe #(
        .NUM_LAYERS (NUM_LAYERS),
        .LW         (LW)
    ) u_next_pe (
        .mask       (mask_q),
        .cur_layer  (cur_layer),
        .next_valid (next_valid),
        .next_idx   (next_idx)
    );

    // First layer of a run comes straight from the incoming mask.
    always_comb begin
        first_sel   = lowest_set_above(MAX_LAYERS'(layer_mask), '0);
        first_valid = |layer_mask;
        first_idx   = layer_mask[0] ? '0 : first_sel.idx[LW-1:0];
    end

    // Qualified events and the move out of a finished layer.
    always_comb begin
        grant       = (state == ST_LAUNCH) || (state == ST_RUN);
        start_acc   = (state == ST_IDLE) && start && !busy;
        abort_acc   = abort && ((state == ST_LAUNCH) ||
                                (state == ST_RUN) ||
                                (state == ST_GUARD));
        run_done    = bus.layer_done[cur_layer];
        wd_inc      = wd + 1'b1;
        timeout_hit = (timeout_limit != '0) && (wd_inc == timeout_limit);
        adv_state   = next_valid ? ST_LAUNCH : ST_FINISH;
        adv_pulse   = next_valid ? (ONE_HOT0 << next_idx) : '0;
    end

    // Sequencer FSM with registered launch pulses and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            mask_q          <= '0;
            wd              <= '0;
            gcnt            <= '0;
            bus.layer_start <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            err_layer       <= '0;
            cur_layer       <= '0;
        end else begin
            bus.layer_start <= '0;
            done            <= 1'b0;
            if (abort_acc) begin
                state     <= ST_FINISH;
                error     <= 1'b1;
                err_layer <= cur_layer;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_acc) begin
                            mask_q <= layer_mask;
                            error  <= 1'b0;
                            busy   <= 1'b1;
                            if (first_valid) begin
                                state           <= ST_LAUNCH;
                                cur_layer       <= first_idx;
                                bus.layer_start <= ONE_HOT0 << first_idx;
                            end else begin
                                state <= ST_FINISH;
                            end
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    ST_LAUNCH: begin
                        wd    <= '0;
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (run_done) begin
                            if (GUARD_CYCLES == 0) begin
                                state           <= adv_state;
                                bus.layer_start <= adv_pulse;
                                if (next_valid) cur_layer <= next_idx;
                            end else begin
                                state <= ST_GUARD;
                                gcnt  <= GUARD_LAST;
                            end
                        end else if (timeout_hit) begin
                            state     <= ST_FINISH;
                            error     <= 1'b1;
                            err_layer <= cur_layer;
                        end else begin
                            wd <= wd_inc;
                        end
                    end
                    ST_GUARD: begin
                        if (gcnt == 4'd0) begin
                            state           <= adv_state;
                            bus.layer_start <= adv_pulse;
                            if (next_valid) cur_layer <= next_idx;
                        end else begin
                            gcnt <= gcnt - 4'd1;
                        end
                    end
                    ST_FINISH: begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // PSRAM grant mux: active engine only, idle bus otherwise.
    always_comb begin
        bus.psram_sck    = PSRAM_IDLE_SCK;
        bus.psram_ce_n   = PSRAM_IDLE_CE_N;
        bus.psram_dout   = PSRAM_IDLE_DOUT;
        bus.psram_douten = PSRAM_IDLE_DOUTEN;
        if (grant) begin
            bus.psram_sck    = bus.eng_sck[cur_layer];
            bus.psram_ce_n   = bus.eng_ce_n[cur_layer];
            bus.psram_dout   = bus.eng_dout[4*cur_layer +: 4];
            bus.psram_douten = bus.eng_douten[4*cur_layer +: 4];
        end
    end

`ifdef KWS_SEQ_PERF_EN
    logic done_acc;

    always_comb begin
        done_acc = (state == ST_RUN) && run_done && !abort;
    end

    // Capture RUN-cycle count of each layer when its done is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (done_acc) begin
            perf_cycles[int'(cur_layer)*TIMEOUT_W +: TIMEOUT_W] <= wd_inc;
        end
    end
`endif

endmodule

// File: tb/tb_kws_layer_sequencer.sv
// Randomised bench for kws_layer_sequencer against a
// timeline model of launches, grants, done and error.
module tb_kws_layer_sequencer;

    localparam int NL   = 4;
    localparam int LWT  = 2;
    localparam int TW   = 20;
    localparam int G    = 2;
    localparam int MAXC = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [NL-1:0]   layer_mask;
    logic [TW-1:0]   timeout_limit;
    logic            busy;
    logic            done;
    logic            error;
    logic [LWT-1:0]  err_layer;
    logic [LWT-1:0]  cur_layer;
`ifdef KWS_SEQ_PERF_EN
    logic [NL*TW-1:0] perf_cycles;
`endif

    kws_layer_sequencer_if #(.NUM_LAYERS(NL)) bus();

    kws_layer_sequencer #(
        .NUM_LAYERS    (NL),
        .LW            (LWT),
        .TIMEOUT_W     (TW),
        .GUARD_CYCLES  (G)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .layer_mask    (layer_mask),
        .timeout_limit (timeout_limit),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_layer     (err_layer),
        .cur_layer     (cur_layer)
`ifdef KWS_SEQ_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [NL-1:0] exp_ls [MAXC];
    int            exp_gr [MAXC];
    bit            exp_busy [MAXC];
    bit            exp_done [MAXC];
    bit            exp_err [MAXC];
    int            exp_errl;
    int            done_rel;
    bit            err_prev;
    bit            err_next;

    int            kd [NL];
    logic [NL-1:0] mask_v;
    int            tlim_v;
    int            abort_v;

    // Timeline of one run, relative to the cycle start is driven.
    task automatic build_model();
        int t, fin, errr, launch, last_act, gend;
        for (int r = 0; r < MAXC; r++) begin
            exp_ls[r]   = '0;
            exp_gr[r]   = -1;
            exp_busy[r] = 1'b0;
            exp_done[r] = 1'b0;
            exp_err[r]  = 1'b0;
        end
        t = 1;
        fin = -1;
        errr = -1;
        exp_errl = 0;
        for (int i = 0; i < NL; i++) begin
            if (mask_v[i] && fin < 0) begin
                launch = t;
                exp_ls[launch][i] = 1'b1;
                if (tlim_v != 0 && kd[i] > tlim_v) last_act = launch + tlim_v;
                else last_act = launch + kd[i] + G;
                if (abort_v >= launch && abort_v <= last_act) begin
                    gend = (abort_v < launch + kd[i]) ? abort_v : launch + kd[i];
                    fin = abort_v + 1;
                    errr = fin;
                    exp_errl = i;
                end else if (tlim_v != 0 && kd[i] > tlim_v) begin
                    gend = launch + tlim_v;
                    fin = gend + 1;
                    errr = fin;
                    exp_errl = i;
                end else begin
                    gend = launch + kd[i];
                    t = launch + kd[i] + 1 + G;
                end
                for (int r = launch; r <= gend; r++) exp_gr[r] = i;
            end
        end
        if (fin < 0) fin = t;
        done_rel = fin + 1;
        for (int r = 1; r <= done_rel; r++) exp_busy[r] = 1'b1;
        exp_done[done_rel] = 1'b1;
        for (int r = 0; r < MAXC; r++)
            exp_err[r] = (r == 0) ? err_prev : (errr >= 0 && r >= errr);
        err_next = (errr >= 0);
    endtask

    // Drive one run cycle by cycle with reactive engines; compare each cycle.
    task automatic run_case(input string name);
        int done_at [NL];
        int g;
        logic [9:0] got_bus, exp_bus;
        build_model();
        for (int i = 0; i < NL; i++) done_at[i] = -1;
        for (int r = 0; r <= done_rel + 1; r++) begin
            start = (r == 0) || (r <= done_rel && $urandom_range(0, 3) == 0);
            layer_mask = (r == 0) ? mask_v : NL'($urandom);
            timeout_limit = TW'(tlim_v);
            abort = (r == abort_v);
            for (int i = 0; i < NL; i++)
                bus.layer_done[i] = (done_at[i] == r) ||
                                    (!mask_v[i] && $urandom_range(0, 1) == 1);
            bus.eng_sck    = NL'($urandom);
            bus.eng_ce_n   = NL'($urandom);
            bus.eng_dout   = (4*NL)'($urandom);
            bus.eng_douten = (4*NL)'($urandom);
            @(negedge clk);
            checks++;
            if (bus.layer_start !== exp_ls[r]) begin
                errors++;
                $display("FAIL %s r=%0d layer_start got %b exp %b",
                         name, r, bus.layer_start, exp_ls[r]);
            end
            checks++;
            if (busy !== exp_busy[r] || done !== exp_done[r]) begin
                errors++;
                $display("FAIL %s r=%0d busy/done got %b%b exp %b%b",
                         name, r, busy, done, exp_busy[r], exp_done[r]);
            end
            checks++;
            if (error !== exp_err[r]) begin
                errors++;
                $display("FAIL %s r=%0d error got %b exp %b",
                         name, r, error, exp_err[r]);
            end
            if (r >= 1 && exp_err[r]) begin
                checks++;
                if (err_layer !== LWT'(exp_errl)) begin
                    errors++;
                    $display("FAIL %s r=%0d err_layer got %0d exp %0d",
                             name, r, err_layer, exp_errl);
                end
            end
            g = exp_gr[r];
            got_bus = {bus.psram_sck, bus.psram_ce_n,
                       bus.psram_dout, bus.psram_douten};
            if (g >= 0) begin
                exp_bus = {bus.eng_sck[g], bus.eng_ce_n[g],
                           bus.eng_dout[4*g +: 4], bus.eng_douten[4*g +: 4]};
                checks++;
                if (cur_layer !== LWT'(g)) begin
                    errors++;
                    $display("FAIL %s r=%0d cur_layer got %0d exp %0d",
                             name, r, cur_layer, g);
                end
            end else begin
                exp_bus = 10'b0_1_0000_0000;
            end
            checks++;
            if (got_bus !== exp_bus) begin
                errors++;
                $display("FAIL %s r=%0d psram bus got %h exp %h",
                         name, r, got_bus, exp_bus);
            end
            for (int i = 0; i < NL; i++)
                if (bus.layer_start[i] === 1'b1) done_at[i] = r + kd[i];
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        bus.layer_done = '0;
        err_prev = err_next;
    endtask

    task automatic test_reset();
        logic [20:0] got;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        layer_mask = '0;
        timeout_limit = '0;
        bus.layer_done = '0;
        bus.eng_sck = '0;
        bus.eng_ce_n = '1;
        bus.eng_dout = '0;
        bus.eng_douten = '0;
        #1 rst = 1'b1;
        #1;
        got = {busy, done, error, err_layer, cur_layer, bus.layer_start,
               bus.psram_sck, bus.psram_ce_n, bus.psram_dout, bus.psram_douten};
        checks++;
        if (got !== 21'b000_00_00_0000_0_1_0000_0000) begin
            errors++;
            $display("FAIL reset_values got %b exp %b", got,
                     21'b000_00_00_0000_0_1_0000_0000);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        err_prev = 1'b0;
    endtask

    task automatic test_all_layers();
        mask_v = 4'b1111;
        for (int i = 0; i < NL; i++) kd[i] = 5;
        tlim_v = 0;
        abort_v = -1;
        run_case("all_layers");
`ifdef KWS_SEQ_PERF_EN
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (perf_cycles[i*TW +: TW] !== TW'(kd[i])) begin
                errors++;
                $display("FAIL perf_slot%0d got %0d exp %0d",
                         i, perf_cycles[i*TW +: TW], kd[i]);
            end
        end
`endif
    endtask

    task automatic test_skip_mask();
        mask_v = 4'b1010;
        for (int i = 0; i < NL; i++) kd[i] = 4;
        tlim_v = 0;
        abort_v = -1;
        run_case("skip_mask");
    endtask

    task automatic test_zero_mask();
        mask_v = 4'b0000;
        tlim_v = 0;
        abort_v = -1;
        run_case("zero_mask");
    endtask

    task automatic test_timeout();
        mask_v = 4'b1111;
        kd[0] = 5;
        kd[1] = 3;
        kd[2] = 1000;
        kd[3] = 5;
        tlim_v = 10;
        abort_v = -1;
        run_case("timeout");
        mask_v = 4'b0001;
        kd[0] = 2;
        tlim_v = 0;
        run_case("restart_after_timeout");
    endtask

    task automatic test_abort();
        mask_v = 4'b1111;
        for (int i = 0; i < NL; i++) kd[i] = 5;
        tlim_v = 0;
        abort_v = 9 + 2;
        run_case("abort_run");
        abort_v = -1;
        mask_v = 4'b0110;
        run_case("restart_after_abort");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            mask_v = NL'($urandom);
            for (int i = 0; i < NL; i++) kd[i] = $urandom_range(1, 6);
            tlim_v = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 7) : 0;
            abort_v = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : -1;
            run_case($sformatf("random%0d", n));
        end
    endtask

    task automatic test_reset_midrun();
        logic [20:0] got;
        mask_v = 4'b1111;
        for (int i = 0; i < NL; i++) kd[i] = 5;
        layer_mask = mask_v;
        timeout_limit = '0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        start = 1'b1;
        bus.layer_done = 4'b0001;
        #1;
        got = {busy, done, error, err_layer, cur_layer, bus.layer_start,
               bus.psram_sck, bus.psram_ce_n, bus.psram_dout, bus.psram_douten};
        checks++;
        if (got !== 21'b000_00_00_0000_0_1_0000_0000) begin
            errors++;
            $display("FAIL reset_midrun got %b exp %b", got,
                     21'b000_00_00_0000_0_1_0000_0000);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.layer_done = '0;
        #2 rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (bus.layer_start !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet n=%0d layer_start got %b busy got %b exp 0",
                         n, bus.layer_start, busy);
            end
            @(posedge clk);
            #1;
        end
        err_prev = 1'b0;
        mask_v = 4'b1001;
        tlim_v = 0;
        abort_v = -1;
        run_case("restart_after_reset");
    endtask

    initial begin
        test_reset();
        test_all_layers();
        test_skip_mask();
        test_zero_mask();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit reached");
        $fatal(1);
    end

endmodule
